flexbex_dmem_arbiter: RTL
=========================

// Module: flexbex_dmem_arbiter
// PURPOSE
//  Shares RW port 0 of the 1 KB data SRAM (sram_1rw1r_32_256_8_sky130) between the ibex data port
//  and a fabric-side master driven from eFPGA user I/O. Generates the gnt/rvalid handshake ibex
//  expects, maps byte addresses to SRAM words, flags out-of-range accesses and counts contention.
//  Sits in flexbex_soc_top between ibex_core, the eFPGA UIO wiring and the SRAM macro.
// PARAMETERS
//  ADDR_W     12  requester byte-address width
//  SRAM_AW    8   SRAM word-address width (256 x 32b)
//  DATA_W     32  data width; byte enables are DATA_W/8
//  FIXED_PRIO 0   0 = round-robin, 1 = core always wins
//  CNT_W      16  width of contention counter
// PORTS
//  clk             in   1        system clock (also drives SRAM clk0)
//  reset           in   1        asynchronous reset, active-high
//  core_req_i / fab_req_i        in  1      access request
//  core_we_i / fab_we_i          in  1      1 = write, 0 = read
//  core_be_i / fab_be_i          in  4      byte enables
//  core_addr_i / fab_addr_i      in  ADDR_W byte address
//  core_wdata_i / fab_wdata_i    in  DATA_W write data
//  core_gnt_o / fab_gnt_o        out 1      request accepted this cycle
//  core_rvalid_o / fab_rvalid_o  out 1      response valid
//  core_rdata_o / fab_rdata_o    out DATA_W read data
//  core_err_o / fab_err_o        out 1      out-of-range response (with rvalid)
//  sram_csb0_o     out  1        chip select, active-low
//  sram_web0_o     out  1        write enable, active-low
//  sram_wmask0_o   out  4        write mask = granted be
//  sram_addr0_o    out  SRAM_AW  word address
//  sram_din0_o     out  DATA_W   write data
//  sram_dout0_i    in   DATA_W   SRAM read data
//  conflict_cnt_o  out  CNT_W    cycles with both req high, saturating
// BEHAVIOUR
//  - Reset: all gnt/rvalid/err = 0, rdata = 0, csb0 = 1, web0 = 1, wmask/addr/din = 0,
//    rr pointer = core, conflict_cnt = 0. Reset mid-access drops pending responses; no rvalid after.
//  - Arbitration is combinational; gnt is asserted in the same cycle as req. At most one gnt per cycle.
//  - Single requester: granted immediately. Both: FIXED_PRIO=1 -> core; else rr pointer picks,
//    pointer flips to the other requester after each contended grant (uncontended grants leave it).
//  - Granted, in range: csb0=0, web0=~we, wmask=be, addr=addr[SRAM_AW+1:2], din=wdata; addr[1:0] ignored.
//  - Out of range (addr[ADDR_W-1:SRAM_AW+2] != 0): gnt given, csb0 stays 1, response has err=1, rdata=0.
//  - No grant: csb0=1, web0=1, other SRAM outputs hold 0.
//  - Response: exactly one cycle after gnt, owner's rvalid=1 for reads and writes. Read rdata =
//    sram_dout0_i in that cycle; write rdata = 0. rdata is 0 whenever rvalid = 0.
//  - Registered response state: owner id, was_read, err; back-to-back grants every cycle allowed,
//    response N overlaps grant N+1 with no bubble.
//  - Requester holding req after gnt is a new request; requester must keep inputs stable until gnt.
//  - conflict_cnt increments on each cycle with both req high (independent of range), saturates at all-ones.
// TESTING
//  1 Core read addr 0x010 after SRAM word 4 holds 0xDEADBEEF -> gnt same cycle, csb0=0 addr0=4,
//    next cycle core_rvalid=1 rdata=0xDEADBEEF, fab_rvalid=0.
//  2 Both req writes every cycle for 4 cycles, FIXED_PRIO=0 -> grants core,fab,core,fab;
//    rvalid follows one cycle later each; conflict_cnt=4.
//  3 FIXED_PRIO=1, both req for 3 cycles -> core granted 3x, fab_gnt=0, conflict_cnt=3.
//  4 Fab write addr 0x400 be=0xF -> fab_gnt=1, csb0=1, next cycle fab_rvalid=1 err=1 rdata=0.
//  5 Core write be=0x3 data 0x12345678 to 0x020, then read 0x020 -> wmask0=0x3; read returns
//    prior upper half with 0x5678 low half.
//  6 Assert reset the cycle after a core read gnt -> no core_rvalid; all outputs at reset values;
//    CNT_W=2 with 5 contended cycles -> conflict_cnt=3.

Source files
------------

// File: rtl/flexbex_dmem_arbiter.sv
// flexbex_dmem_arbiter: shares SRAM RW port 0 between the ibex data port
// and the eFPGA fabric master, producing gnt/rvalid responses and a conflict count.
module flexbex_dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int SRAM_AW    = 8,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    output logic                core_err_o,
    input  logic                fab_req_i,
    input  logic                fab_we_i,
    input  logic [DATA_W/8-1:0] fab_be_i,
    input  logic [ADDR_W-1:0]   fab_addr_i,
    input  logic [DATA_W-1:0]   fab_wdata_i,
    output logic                fab_gnt_o,
    output logic                fab_rvalid_o,
    output logic [DATA_W-1:0]   fab_rdata_o,
    output logic                fab_err_o,
    output logic                sram_csb0_o,
    output logic                sram_web0_o,
    output logic [DATA_W/8-1:0] sram_wmask0_o,
    output logic [SRAM_AW-1:0]  sram_addr0_o,
    output logic [DATA_W-1:0]   sram_din0_o,
    input  logic [DATA_W-1:0]   sram_dout0_i,
    output logic [CNT_W-1:0]    conflict_cnt_o
);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_FAB  = 1'b1
    } owner_e;

    owner_e rr_ptr;
    owner_e rsp_owner;
    logic   rsp_valid;
    logic   rsp_read;
    logic   rsp_err;

    logic                both_req;
    logic                core_win;
    logic                fab_win;
    logic                any_gnt;
    logic                sel_we;
    logic [DATA_W/8-1:0] sel_be;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_range;
    logic [DATA_W-1:0]   rsp_data;
    logic                unused_addr_lsb;

    assign both_req = core_req_i & fab_req_i;

    // Pick at most one winner; nothing is granted while reset is held.
    always_comb begin
        core_win = 1'b0;
        fab_win  = 1'b0;
        if (!reset) begin
            if (both_req) begin
                if (FIXED_PRIO != 0 || rr_ptr == OWN_CORE) begin
                    core_win = 1'b1;
                end else begin
                    fab_win = 1'b1;
                end
            end else begin
                core_win = core_req_i;
                fab_win  = fab_req_i;
            end
        end
    end

    assign core_gnt_o = core_win;
    assign fab_gnt_o  = fab_win;
    assign any_gnt    = core_win | fab_win;

    // Route the winning request's fields toward the SRAM.
    always_comb begin
        sel_we    = core_we_i;
        sel_be    = core_be_i;
        sel_addr  = core_addr_i;
        sel_wdata = core_wdata_i;
        if (fab_win) begin
            sel_we    = fab_we_i;
            sel_be    = fab_be_i;
            sel_addr  = fab_addr_i;
            sel_wdata = fab_wdata_i;
        end
    end

    assign in_range        = (sel_addr[ADDR_W-1:SRAM_AW+2] == '0);
    assign unused_addr_lsb = ^sel_addr[1:0];

    // Drive the macro only for an in-range grant; otherwise park it idle.
    always_comb begin
        sram_csb0_o   = 1'b1;
        sram_web0_o   = 1'b1;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        if (any_gnt && in_range) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = ~sel_we;
            sram_wmask0_o = sel_be;
            sram_addr0_o  = sel_addr[SRAM_AW+1:2];
            sram_din0_o   = sel_wdata;
        end
    end

    // Remember who was granted so the response lands one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_owner <= OWN_CORE;
            rsp_read  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_owner <= fab_win ? OWN_FAB : OWN_CORE;
            rsp_read  <= any_gnt & ~sel_we;
            rsp_err   <= any_gnt & ~in_range;
        end
    end

    // Hand priority to the loser after every contended grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= OWN_CORE;
        end else if (both_req && FIXED_PRIO == 0) begin
            rr_ptr <= (rr_ptr == OWN_CORE) ? OWN_FAB : OWN_CORE;
        end
    end

    // Saturating count of cycles where both masters request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_o <= '0;
        end else if (both_req && conflict_cnt_o != {CNT_W{1'b1}}) begin
            conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
        end
    end

    assign rsp_data = (rsp_valid && rsp_read && !rsp_err) ? sram_dout0_i : '0;

    assign core_rvalid_o = rsp_valid && (rsp_owner == OWN_CORE);
    assign fab_rvalid_o  = rsp_valid && (rsp_owner == OWN_FAB);
    assign core_err_o    = core_rvalid_o & rsp_err;
    assign fab_err_o     = fab_rvalid_o & rsp_err;
    assign core_rdata_o  = core_rvalid_o ? rsp_data : '0;
    assign fab_rdata_o   = fab_rvalid_o ? rsp_data : '0;

endmodule
